// File: rtl/adder_bist_pkg.sv
// Shared types and constants for the 64-bit adder BIST engine.
package adder_bist_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } bist_state_e;

    // Galois right-shift mask for x^64 + x^63 + x^61 + x^60 + 1
    localparam logic [63:0] LfsrTaps = 64'hD800_0000_0000_0000;

    // Corner vectors, packed as {a, b}
    localparam logic [127:0] CornerVec0 = {64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000};
    localparam logic [127:0] CornerVec1 = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001};
    localparam logic [127:0] CornerVec2 = {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    localparam logic [127:0] CornerVec3 = {64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA};

    localparam logic [15:0] NoErrIdx = 16'hFFFF;

    function automatic logic [127:0] corner_vec(input logic [1:0] sel);
        logic [127:0] v;
        unique case (sel)
            2'd0:    v = CornerVec0;
            2'd1:    v = CornerVec1;
            2'd2:    v = CornerVec2;
            default: v = CornerVec3;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/adder_bist_64u_lfsr.sv
// 64-bit Galois LFSR with synchronous seed load; load takes priority over step.
module bist_lfsr64
    import adder_bist_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [63:0] seed,
    input  logic        step,
    output logic [63:0] q
);

    logic [63:0] state_q;
    logic [63:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = seed;
        end else if (step) begin
            state_d = (state_q >> 1) ^ (state_q[0] ? LfsrTaps : 64'h0);
        end
    end

    // Nonzero reset value so the register never idles in the lock-up state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= 64'h1;
        end else begin
            state_q <= state_d;
        end
    end

    assign q = state_q;

endmodule

// File: rtl/adder_bist_64u.sv
// BIST engine: issues corner + LFSR vectors to a registered adder and checks its results.
module adder_bist_64u
    import adder_bist_pkg::*;
#(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned N_VECTORS = 1024,
    parameter int unsigned LATENCY   = 2,
    parameter logic [63:0] SEED_A    = 64'h0123_4567_89AB_CDEF,
    parameter logic [63:0] SEED_B    = 64'hFEDC_BA98_7654_3211
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    input  logic [WIDTH-1:0] dut_sum,
    input  logic             dut_cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic [15:0]      first_err_idx
);

    localparam logic [15:0] LastIdx   = 16'(N_VECTORS - 1);
    localparam logic [15:0] LastDrain = 16'(LATENCY - 1);

    bist_state_e state_q, state_d;
    logic [15:0] idx_q, idx_d;
    logic [15:0] drain_q, drain_d;
    logic [63:0] a_q, a_d, b_q, b_d;
    logic [15:0] err_q, err_d;
    logic [15:0] first_q, first_d;

    logic        lfsr_load, lfsr_step;
    logic [63:0] lfsr_a, lfsr_b;
    logic [15:0] idx_nxt;
    logic        start_acc;

    // Expected-result delay line; index LATENCY-1 is the head being compared
    logic [LATENCY-1:0]       dl_vld_q;
    logic [LATENCY-1:0][64:0] dl_exp_q;
    logic [LATENCY-1:0][15:0] dl_idx_q;

    bist_lfsr64 u_lfsr_a (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .seed  (SEED_A),
        .step  (lfsr_step),
        .q     (lfsr_a)
    );

    bist_lfsr64 u_lfsr_b (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .seed  (SEED_B),
        .step  (lfsr_step),
        .q     (lfsr_b)
    );

    assign idx_nxt   = idx_q + 16'd1;
    assign start_acc = start && ((state_q == StIdle) || (state_q == StDone));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        drain_d   = drain_q;
        a_d       = 64'h0;
        b_d       = 64'h0;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d    = StRun;
                    idx_d      = 16'd0;
                    {a_d, b_d} = corner_vec(2'd0);
                    lfsr_load  = 1'b1;
                end
            end
            StRun: begin
                if (idx_q == LastIdx) begin
                    state_d = StDrain;
                    drain_d = 16'd0;
                end else begin
                    idx_d = idx_nxt;
                    if (idx_nxt < 16'd4) begin
                        {a_d, b_d} = corner_vec(idx_nxt[1:0]);
                    end else begin
                        a_d       = lfsr_a;
                        b_d       = lfsr_b;
                        lfsr_step = 1'b1;
                    end
                end
            end
            StDrain: begin
                if (drain_q == LastDrain) begin
                    state_d = StDone;
                end else begin
                    drain_d = drain_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        err_d   = err_q;
        first_d = first_q;
        if (dl_vld_q[LATENCY-1] && ({dut_cout, dut_sum} != dl_exp_q[LATENCY-1])) begin
            if (err_q == 16'd0) begin
                first_d = dl_idx_q[LATENCY-1];
            end
            if (err_q != 16'hFFFF) begin
                err_d = err_q + 16'd1;
            end
        end
        if (start_acc) begin
            err_d   = 16'd0;
            first_d = NoErrIdx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= 16'd0;
            drain_q <= 16'd0;
            a_q     <= 64'h0;
            b_q     <= 64'h0;
            err_q   <= 16'd0;
            first_q <= NoErrIdx;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            drain_q <= drain_d;
            a_q     <= a_d;
            b_q     <= b_d;
            err_q   <= err_d;
            first_q <= first_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_vld_q <= '0;
            dl_exp_q <= '0;
            dl_idx_q <= '0;
        end else begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                dl_vld_q[i] <= dl_vld_q[i-1];
                dl_exp_q[i] <= dl_exp_q[i-1];
                dl_idx_q[i] <= dl_idx_q[i-1];
            end
            dl_vld_q[0] <= (state_q == StRun);
            dl_exp_q[0] <= {1'b0, a_q} + {1'b0, b_q};
            dl_idx_q[0] <= idx_q;
        end
    end

    assign a_out         = a_q;
    assign b_out         = b_q;
    assign busy          = (state_q == StRun) || (state_q == StDrain);
    assign done          = (state_q == StDone);
    assign pass          = done && (err_q == 16'd0);
    assign err_count     = err_q;
    assign first_err_idx = first_q;

endmodule

// File: tb/tb_adder_bist_64u.sv
// Bench: BIST engine against a behavioural 2-stage adder with injectable result faults.
module tb_adder_bist_64u;

    localparam int unsigned N   = 16;
    localparam int unsigned LAT = 2;
    localparam logic [63:0] SA  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] SB  = 64'hFEDC_BA98_7654_3211;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [63:0] a_out, b_out, dut_sum;
    logic        dut_cout, busy, done, pass;
    logic [15:0] err_count, first_err_idx;

    logic [64:0] p1 = '0;
    logic [64:0] p2 = '0;
    logic [64:0] obs;
    int          cyc = 1000;
    int          k;
    logic        stuck_cout = 1'b0;
    logic [64:0] fault_mask [N];

    logic [63:0] va [N];
    logic [63:0] vb [N];
    int          exp_err;
    logic [15:0] exp_first;
    int          n_tests = 0;
    int          n_fail = 0;

    adder_bist_64u #(
        .WIDTH     (64),
        .N_VECTORS (N),
        .LATENCY   (LAT),
        .SEED_A    (SA),
        .SEED_B    (SB)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .a_out         (a_out),
        .b_out         (b_out),
        .dut_sum       (dut_sum),
        .dut_cout      (dut_cout),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_idx (first_err_idx)
    );

    always #5 clk = ~clk;

    // Behavioural registered adder; cyc is 0 in the first cycle after an accepted start
    always @(posedge clk) begin
        p1 <= {1'b0, a_out} + {1'b0, b_out};
        p2 <= p1;
        if (start && !busy) cyc <= 0;
        else                cyc <= cyc + 1;
    end

    always_comb begin
        obs = p2;
        k   = cyc - int'(LAT);
        if (k >= 0 && k < int'(N)) obs = obs ^ fault_mask[k];
        if (stuck_cout) obs[64] = 1'b0;
    end

    assign dut_sum  = obs[63:0];
    assign dut_cout = obs[64];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] lfsr_next(input logic [63:0] x);
        return (x >> 1) ^ (x[0] ? 64'hD800_0000_0000_0000 : 64'h0);
    endfunction

    task automatic build_model();
        logic [63:0] sa, sb;
        logic [64:0] truth, seen;
        va[0] = 64'h0;                   vb[0] = 64'h0;
        va[1] = 64'hFFFF_FFFF_FFFF_FFFF; vb[1] = 64'h1;
        va[2] = 64'hFFFF_FFFF_FFFF_FFFF; vb[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        va[3] = 64'h5555_5555_5555_5555; vb[3] = 64'hAAAA_AAAA_AAAA_AAAA;
        sa = SA;
        sb = SB;
        for (int i = 4; i < int'(N); i++) begin
            va[i] = sa;
            vb[i] = sb;
            sa = lfsr_next(sa);
            sb = lfsr_next(sb);
        end
        exp_err   = 0;
        exp_first = 16'hFFFF;
        for (int i = 0; i < int'(N); i++) begin
            truth = {1'b0, va[i]} + {1'b0, vb[i]};
            seen  = truth ^ fault_mask[i];
            if (stuck_cout) seen[64] = 1'b0;
            if (seen != truth) begin
                if (exp_err == 0) exp_first = 16'(i);
                exp_err++;
            end
        end
    endtask

    task automatic clear_faults();
        for (int i = 0; i < int'(N); i++) fault_mask[i] = '0;
        stuck_cout = 1'b0;
    endtask

    task automatic run(input string tag, input bit mid_start);
        int cnt;
        build_model();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check_eq({tag, " busy_rise"}, 128'(busy), 128'd1);
        check_eq({tag, " done_clr"}, 128'(done), 128'd0);
        cnt = 0;
        while (busy && cnt < 200) begin
            if (cnt < int'(N)) begin
                check_eq($sformatf("%s a[%0d]", tag, cnt), 128'(a_out), 128'(va[cnt]));
                check_eq($sformatf("%s b[%0d]", tag, cnt), 128'(b_out), 128'(vb[cnt]));
            end
            start = mid_start && (cnt == 5);
            cnt++;
            @(negedge clk);
        end
        start = 1'b0;
        check_eq({tag, " busy_cycles"}, 128'(cnt), 128'(N + LAT));
        check_eq({tag, " done"}, 128'(done), 128'd1);
        check_eq({tag, " pass"}, 128'(pass), 128'(exp_err == 0));
        check_eq({tag, " err_count"}, 128'(err_count), 128'(exp_err));
        check_eq({tag, " first_err"}, 128'(first_err_idx), 128'(exp_first));
        repeat (3) @(negedge clk);
        check_eq({tag, " err_hold"}, 128'(err_count), 128'(exp_err));
        check_eq({tag, " first_hold"}, 128'(first_err_idx), 128'(exp_first));
        check_eq({tag, " a_idle"}, 128'(a_out), 128'd0);
    endtask

    initial begin
        int saved_err;
        logic [15:0] saved_first;
        clear_faults();
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst a_out", 128'(a_out), 128'd0);
        check_eq("rst b_out", 128'(b_out), 128'd0);
        check_eq("rst busy", 128'(busy), 128'd0);
        check_eq("rst done", 128'(done), 128'd0);
        check_eq("rst pass", 128'(pass), 128'd0);
        check_eq("rst err", 128'(err_count), 128'd0);
        check_eq("rst first", 128'(first_err_idx), 128'hFFFF);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run("clean", 1'b0);

        fault_mask[5] = 65'd1;
        run("bit0_v5", 1'b0);
        check_eq("bit0_v5 model", 128'(exp_first), 128'd5);

        clear_faults();
        stuck_cout = 1'b1;
        run("stuck_cout", 1'b0);
        check_eq("stuck_cout first1", 128'(first_err_idx), 128'd1);
        check_eq("stuck_cout ge2", 128'(err_count >= 16'd2), 128'd1);
        saved_err   = int'(err_count);
        saved_first = first_err_idx;
        run("back2back", 1'b0);
        check_eq("b2b err_same", 128'(err_count), 128'(saved_err));
        check_eq("b2b first_same", 128'(first_err_idx), 128'(saved_first));

        clear_faults();
        run("mid_start", 1'b1);

        fault_mask[0] = 65'h1_0000_0000_0000_0000;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("pre_rst err", 128'(err_count), 128'd1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst busy", 128'(busy), 128'd0);
        check_eq("midrst done", 128'(done), 128'd0);
        check_eq("midrst a_out", 128'(a_out), 128'd0);
        check_eq("midrst err", 128'(err_count), 128'd0);
        check_eq("midrst first", 128'(first_err_idx), 128'hFFFF);
        @(negedge clk) rst_n = 1'b1;
        clear_faults();
        run("restart", 1'b0);

        for (int r = 0; r < 3; r++) begin
            clear_faults();
            for (int i = 0; i < int'(N); i++) begin
                if ($urandom_range(0, 3) == 0) fault_mask[i] = 65'd1 << $urandom_range(0, 64);
            end
            stuck_cout = ($urandom_range(0, 1) == 1);
            run($sformatf("rand%0d", r), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_bist_64u.md
# adder_bist_64u

Built-in self-test engine for the registered 64-bit prefix-adder wrappers (e.g. `adder_sklansky_64u_wrapper`).
- Drives the wrapper's `a`/`b` inputs with directed corner vectors followed by pseudo-random vectors.
- Compares the wrapper's registered `sum`/`cout` against an internal behavioural reference, accounting for the wrapper's pipeline latency.
- Reports pass/fail, an error count and the index of the first failing vector.
- Sits beside any adder wrapper for on-silicon or gate-level regression of the prefix-adder runs.

## Interface
Parameters:
- `WIDTH`, 64: operand width; fixed at 64 for this revision.
- `N_VECTORS`, 1024: vectors per run; legal range 4..65535.
- `LATENCY`, 2: cycles from a vector appearing on `a_out` to its result appearing on `dut_sum`/`dut_cout`.
- `SEED_A`, 64'h0123_4567_89AB_CDEF: LFSR seed for A; must be nonzero.
- `SEED_B`, 64'hFEDC_BA98_7654_3211: LFSR seed for B; must be nonzero.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle run request.
- `a_out` out 64: operand A to the DUT.
- `b_out` out 64: operand B to the DUT.
- `dut_sum` in 64: DUT sum.
- `dut_cout` in 1: DUT carry-out.
- `busy` out 1: run in progress.
- `done` out 1: results valid; held until the next start.
- `pass` out 1: `done && err_count == 0`.
- `err_count` out 16: mismatching vectors; saturates at 16'hFFFF.
- `first_err_idx` out 16: index of the first mismatch; 16'hFFFF if none.

## Operation
- **FSM states:** IDLE, RUN, DRAIN, DONE.
- **IDLE/DONE → RUN** on `start`=1.
  - Vector index, error count and first-error index are cleared.
  - Both LFSRs reload their seeds.
- **RUN:** issues one vector per cycle, indices 0..N_VECTORS-1. Moves to DRAIN after index N_VECTORS-1 is issued.
- **DRAIN:** lasts LATENCY cycles, then moves to DONE.
- **`start` handling:** ignored in RUN and DRAIN. In DONE it starts a new run.
- **Vector sequence:**
  - idx 0: 0 + 0.
  - idx 1: all-ones + 1.
  - idx 2: all-ones + all-ones.
  - idx 3: 0x5555…5 + 0xAAAA…A.
  - idx ≥4: A = LFSR_A state, B = LFSR_B state. Each LFSR steps once per issued random vector.
- **LFSR:** 64-bit Galois, polynomial x^64+x^63+x^61+x^60+1.
- **Reference model:** expected = 65-bit `{1'b0,a} + {1'b0,b}`, carried with a valid bit and the 16-bit index through a LATENCY-deep delay line.
- **Compare:** when the delay-line head is valid, compare `{dut_cout,dut_sum}` with the expected value.
  - On mismatch, increment `err_count` (saturating).
  - If this is the first error, latch the head's index into `first_err_idx`.
- **Operands outside RUN:** `a_out`/`b_out` are driven to 0; no comparison occurs.

## Timing
- **Reset values:** `a_out`=0, `b_out`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_err_idx`=16'hFFFF. State is IDLE and the delay line is all-invalid.
- **Reset mid-run:** asynchronous return to the reset values above. No partial results are retained.
- **Run timeline:** `start` sampled at edge E.
  - Vector i is on `a_out`/`b_out` in cycle E+1+i. `a_out`/`b_out` are registered.
  - Vector i is compared at the edge ending cycle E+1+i+LATENCY.
  - `busy`=1 for cycles E+1 .. E+N_VECTORS+LATENCY.
  - `done`=1 from cycle E+N_VECTORS+LATENCY+1.
- **`done` clearing:** cleared in the cycle after a `start` accepted in DONE; `busy` rises in that same cycle.
- **Outputs stable in DONE:** `err_count`, `first_err_idx` and `pass` do not change until the next accepted `start` or reset.
- **Zero-error run:** `first_err_idx` stays 16'hFFFF.

## Structure
- **Package `adder_bist_pkg`** holds:
  - the state enum;
  - the LFSR polynomial tap constant;
  - the four corner-vector constants;
  - the 16'hFFFF no-error sentinel.
- **Sub-module `bist_lfsr64`:** ports `clk`, `rst_n`, `load`, `seed`, `step`, `q`; instantiated twice (A and B).
- **Top level:** FSM, index counter, delay line and compare logic stay in the top level.

## Test plan
All scenarios use a bench with `adder_bist_64u` connected to `adder_sklansky_64u_wrapper`.
1. **Reset:** `rst_n` low → all outputs at reset values; `first_err_idx`=16'hFFFF.
2. **Fault-free run:** N_VECTORS=16, pulse `start` → `busy` high exactly 18 cycles; `done`=1, `pass`=1, `err_count`=0. Vector idx1 shows `a_out`=all-ones, `b_out`=1.
3. **Single-bit fault:** bench flips `dut_sum[0]` only while the vector-5 result is presented → `err_count`=1, `first_err_idx`=5, `pass`=0.
4. **Stuck carry:** bench forces `dut_cout`=0 → idx1 and idx2 fail, so `first_err_idx`=1 and `err_count` ≥ 2.
5. **Start handling and reset mid-run:**
   - `start` pulsed during RUN → no effect on the cycle count.
   - `rst_n` asserted mid-run, then a new `start` → `busy`/`done` cleared immediately; the `a_out` sequence after restart is bit-identical to the first run.
6. **Back-to-back runs:** `start` pulsed in DONE → results cleared; the second run reproduces the same `err_count` and `first_err_idx`.
